lsu_bus_arbiter: RTL and testbench

LSU_BUS_ARBITER -- requirements
Module: lsu_bus_arbiter

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/lsu_bus_arbiter_if.sv | 25 ++
 rtl/rr_pick2.sv | 14 +
 rtl/lsu_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_lsu_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the LSU bus arbiter: FSM states, master indices
// and bus field widths.
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lsu_bus_arbiter_if.sv
// One simple load/store bus port: request fields toward the slave side and
// completion pulses plus read data back toward the master side.
interface lsu_bus_arbiter_if;
  import bus_arb_pkg::*;

  logic              rready;
  logic              wvalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] strb;
  logic              rvalid;
  logic              wready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output rready, wvalid, addr, wdata, strb,
    input  rvalid, wready, rdata
  );

  modport slave (
    input  rready, wvalid, addr, wdata, strb,
    output rvalid, wready, rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to prio_i.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       grant_idx_o,
  output logic       grant_valid_o
);

  assign grant_valid_o = |req_i;
  assign grant_idx_o   = (&req_i) ? prio_i : (req_i[1] ? M_DMA : M_CPU);

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Arbitrates the CPU LSU and DMA/debug masters onto one shared slave, with a
// per-access response timeout and a sticky timeout flag.
module lsu_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_bus_arbiter_if.slave  m0_bus,
  lsu_bus_arbiter_if.slave  m1_bus,
  lsu_bus_arbiter_if.master s_bus,
  output logic              owner_o,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]        req;
  logic              grant_idx, grant_valid;
  logic              sel_rready, sel_wvalid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;
  logic              busy, is_wr, rd_req;
  logic              resp_ok, tmo_hit, complete, cpl_rd, cpl_wr;
  logic [DATA_W-1:0] cpl_rdata;

  assign req[M_CPU] = m0_bus.rready | m0_bus.wvalid;
  assign req[M_DMA] = m1_bus.rready | m1_bus.wvalid;

  rr_pick2 u_pick (
    .req_i         (req),
    .prio_i        (prio_q),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    sel_rready = m0_bus.rready;
    sel_wvalid = m0_bus.wvalid;
    sel_addr   = m0_bus.addr;
    sel_wdata  = m0_bus.wdata;
    sel_strb   = m0_bus.strb;
    if (owner_q == M_DMA) begin
      sel_rready = m1_bus.rready;
      sel_wvalid = m1_bus.wvalid;
      sel_addr   = m1_bus.addr;
      sel_wdata  = m1_bus.wdata;
      sel_strb   = m1_bus.strb;
    end
  end

  // A simultaneous read+write request is treated as a write.
  assign busy      = (state_q == BUSY);
  assign is_wr     = sel_wvalid;
  assign rd_req    = sel_rready & ~sel_wvalid;
  assign resp_ok   = busy & (is_wr ? s_bus.wready : (rd_req & s_bus.rvalid));
  assign tmo_hit   = busy & ~resp_ok & (cnt_q == CNT_MAX);
  assign complete  = resp_ok | tmo_hit;
  assign cpl_wr    = complete & is_wr;
  assign cpl_rd    = complete & ~is_wr;
  assign cpl_rdata = resp_ok ? s_bus.rdata : ERR_RDATA;

  assign s_bus.rready = busy & rd_req;
  assign s_bus.wvalid = busy & is_wr;
  assign s_bus.addr   = busy ? sel_addr  : '0;
  assign s_bus.wdata  = busy ? sel_wdata : '0;
  assign s_bus.strb   = busy ? sel_strb  : '0;

  assign m0_bus.wready = cpl_wr & (owner_q == M_CPU);
  assign m0_bus.rvalid = cpl_rd & (owner_q == M_CPU);
  assign m0_bus.rdata  = m0_bus.rvalid ? cpl_rdata : '0;
  assign m1_bus.wready = cpl_wr & (owner_q == M_DMA);
  assign m1_bus.rvalid = cpl_rd & (owner_q == M_DMA);
  assign m1_bus.rdata  = m1_bus.rvalid ? cpl_rdata : '0;

  assign owner_o       = owner_q;
  assign busy_o        = busy;
  assign timeout_err_o = terr_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = BUSY;
          owner_d = grant_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (complete) begin
          state_d = DONE;
          prio_d  = ~owner_q;
          if (tmo_hit) terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= M_CPU;
      prio_q  <= M_CPU;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Directed bench for lsu_bus_arbiter: a cycle-by-cycle vector table plus
// hand-written reset, round-robin and timeout sequences.
module tb_lsu_bus_arbiter;

  localparam logic [31:0] WD0  = 32'hC0C0_0001;
  localparam logic [31:0] WD1  = 32'hD0D0_0002;
  localparam logic [3:0]  SB0  = 4'hF;
  localparam logic [3:0]  SB1  = 4'h3;
  localparam logic [31:0] A0W  = 32'h0000_0200;
  localparam logic [31:0] A1W  = 32'h0000_0300;
  localparam logic [31:0] A0R  = 32'h0000_0100;
  localparam logic [31:0] RD   = 32'h1234_5678;
  localparam int          NVEC = 13;

  // Request {wvalid,rready}, slave response {wready,rvalid}, forwarded
  // request {s_wvalid,s_rready}, completion {wready,rvalid}.
  typedef struct {
    logic [1:0]  m0Req;
    logic [31:0] m0Addr;
    logic [1:0]  m1Req;
    logic [31:0] m1Addr;
    logic [1:0]  sResp;
    logic [31:0] sRdata;
    logic        expBusy;
    logic        expOwner;
    logic [1:0]  expSReq;
    logic [31:0] expSAddr;
    logic [1:0]  expM0Cpl;
    logic [31:0] expM0Rdata;
    logic [1:0]  expM1Cpl;
    logic [31:0] expM1Rdata;
    logic        expTerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owner, busy, terr;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t vecs [NVEC];

  lsu_bus_arbiter_if m0_bus ();
  lsu_bus_arbiter_if m1_bus ();
  lsu_bus_arbiter_if s_bus ();

  lsu_bus_arbiter #(
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_bus        (m0_bus),
    .m1_bus        (m1_bus),
    .s_bus         (s_bus),
    .owner_o       (owner),
    .busy_o        (busy),
    .timeout_err_o (terr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_bus.rready = v.m0Req[0];
    m0_bus.wvalid = v.m0Req[1];
    m0_bus.addr   = v.m0Addr;
    m1_bus.rready = v.m1Req[0];
    m1_bus.wvalid = v.m1Req[1];
    m1_bus.addr   = v.m1Addr;
    s_bus.rvalid  = v.sResp[0];
    s_bus.wready  = v.sResp[1];
    s_bus.rdata   = v.sRdata;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(v.expBusy));
    checkOutput($sformatf("v%0d s_req", i), 32'({s_bus.wvalid, s_bus.rready}), 32'(v.expSReq));
    checkOutput($sformatf("v%0d s_strb", i), 32'(s_bus.strb),
                32'(v.expBusy ? (v.expOwner ? SB1 : SB0) : 4'h0));
    if (v.expBusy) begin
      checkOutput($sformatf("v%0d owner", i), 32'(owner), 32'(v.expOwner));
      checkOutput($sformatf("v%0d s_addr", i), s_bus.addr, v.expSAddr);
      checkOutput($sformatf("v%0d s_wdata", i), s_bus.wdata, v.expOwner ? WD1 : WD0);
    end
    checkOutput($sformatf("v%0d m0_cpl", i), 32'({m0_bus.wready, m0_bus.rvalid}), 32'(v.expM0Cpl));
    checkOutput($sformatf("v%0d m0_rdata", i), m0_bus.rdata, v.expM0Rdata);
    checkOutput($sformatf("v%0d m1_cpl", i), 32'({m1_bus.wready, m1_bus.rvalid}), 32'(v.expM1Cpl));
    checkOutput($sformatf("v%0d m1_rdata", i), m1_bus.rdata, v.expM1Rdata);
    checkOutput($sformatf("v%0d timeout_err", i), 32'(terr), 32'(v.expTerr));
  endtask

  task automatic checkAllQuiet(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " s_req"}, 32'({s_bus.wvalid, s_bus.rready}), 32'd0);
    checkOutput({tag, " s_strb"}, 32'(s_bus.strb), 32'd0);
    checkOutput({tag, " s_addr"}, s_bus.addr, 32'd0);
    checkOutput({tag, " m_cpl"},
                32'({m0_bus.wready, m0_bus.rvalid, m1_bus.wready, m1_bus.rvalid}), 32'd0);
    checkOutput({tag, " m_rdata"}, m0_bus.rdata | m1_bus.rdata, 32'd0);
  endtask

  initial begin
    int n, nAt, lastCpl;
    bit got, early, terrEarly;
    logic [31:0] rdAt;
    logic        terrAt, m0At;

    m0_bus.rready = 1'b0; m0_bus.wvalid = 1'b0; m0_bus.addr = '0;
    m0_bus.wdata  = WD0;  m0_bus.strb   = SB0;
    m1_bus.rready = 1'b0; m1_bus.wvalid = 1'b0; m1_bus.addr = '0;
    m1_bus.wdata  = WD1;  m1_bus.strb   = SB1;
    s_bus.rvalid  = 1'b0; s_bus.wready  = 1'b0; s_bus.rdata = '0;

    // Both write after reset (DMA also raises rready), then CPU read alone.
    vecs[0]  = '{2'b10, A0W, 2'b11, A1W, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[1]  = '{2'b10, A0W, 2'b11, A1W, 2'b01, RD,    1'b1, 1'b0, 2'b10, A0W,   2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[2]  = '{2'b10, A0W, 2'b11, A1W, 2'b10, 32'h0, 1'b1, 1'b0, 2'b10, A0W,   2'b10, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[3]  = '{2'b00, A0W, 2'b11, A1W, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[4]  = '{2'b00, A0W, 2'b11, A1W, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[5]  = '{2'b00, A0W, 2'b11, A1W, 2'b11, RD,    1'b1, 1'b1, 2'b10, A1W,   2'b00, 32'h0, 2'b10, 32'h0, 1'b0};
    vecs[6]  = '{2'b00, A0W, 2'b00, A1W, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[7]  = '{2'b01, A0R, 2'b00, A1W, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[8]  = '{2'b01, A0R, 2'b00, A1W, 2'b00, 32'h0, 1'b1, 1'b0, 2'b01, A0R,   2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[9]  = '{2'b01, A0R, 2'b00, A1W, 2'b00, 32'h0, 1'b1, 1'b0, 2'b01, A0R,   2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[10] = '{2'b01, A0R, 2'b00, A1W, 2'b01, RD,    1'b1, 1'b0, 2'b01, A0R,   2'b01, RD,    2'b00, 32'h0, 1'b0};
    vecs[11] = '{2'b00, A0R, 2'b00, A1W, 2'b01, RD,    1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};
    vecs[12] = '{2'b00, A0R, 2'b00, A1W, 2'b01, RD,    1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    checkAllQuiet("reset");
    checkOutput("reset owner", 32'(owner), 32'd0);
    checkOutput("reset timeout_err", 32'(terr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end
    @(negedge clk);
    s_bus.rvalid = 1'b0;

    // Reset in the middle of a CPU read; prio is DMA-favoured beforehand.
    m0_bus.rready = 1'b1; m0_bus.addr = 32'h0000_0700;
    @(negedge clk);
    #1;
    checkOutput("rst_mid busy before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllQuiet("rst_mid asserted");
    m0_bus.rready = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0BAD_0BAD;
    #1;
    checkOutput("rst_mid late rvalid", 32'(m0_bus.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checkAllQuiet($sformatf("rst_mid after%0d", c));
    end
    s_bus.rvalid = 1'b0;

    // Both masters read continuously: grants alternate, CPU first.
    m0_bus.rready = 1'b1; m0_bus.addr = 32'h0000_4000;
    m1_bus.rready = 1'b1; m1_bus.addr = 32'h0000_4100;
    lastCpl = 0;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        s_bus.rvalid = 1'b0;
        #1;
        if (busy) begin
          got = 1'b1;
          break;
        end
      end
      checkOutput($sformatf("rr%0d grant seen", k), 32'(got), 32'd1);
      checkOutput($sformatf("rr%0d owner", k), 32'(owner), 32'(k % 2));
      checkOutput($sformatf("rr%0d s_addr", k), s_bus.addr, (k % 2) ? 32'h0000_4100 : 32'h0000_4000);
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h5000_0000 + 32'(k);
      #1;
      checkOutput($sformatf("rr%0d owner rdata", k),
                  (k % 2) ? m1_bus.rdata : m0_bus.rdata, 32'h5000_0000 + 32'(k));
      checkOutput($sformatf("rr%0d other rvalid", k),
                  32'((k % 2) ? m0_bus.rvalid : m1_bus.rvalid), 32'd0);
      if (k > 0) checkOutput($sformatf("rr%0d spacing", k), 32'(cyc - lastCpl), 32'd3);
      lastCpl = cyc;
    end
    @(negedge clk);
    s_bus.rvalid = 1'b0;
    m0_bus.rready = 1'b0; m1_bus.rready = 1'b0;
    repeat (2) @(negedge clk);

    // CPU read answered exactly in the threshold cycle.
    m0_bus.rready = 1'b1; m0_bus.addr = 32'h0000_0800;
    n = 0; got = 1'b0; early = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (busy) n++;
      if (n == 8) begin
        s_bus.rvalid = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("thr m0_rvalid", 32'(m0_bus.rvalid), 32'd1);
        checkOutput("thr m0_rdata", m0_bus.rdata, 32'hCAFE_F00D);
        got = 1'b1;
        break;
      end
      if (m0_bus.rvalid) early = 1'b1;
    end
    checkOutput("thr reached", 32'(got), 32'd1);
    checkOutput("thr no early pulse", 32'(early), 32'd0);
    @(negedge clk);
    s_bus.rvalid = 1'b0; m0_bus.rready = 1'b0;
    #1;
    checkOutput("thr timeout_err", 32'(terr), 32'd0);
    repeat (2) @(negedge clk);

    // DMA read with a silent slave times out after 8 BUSY cycles.
    m1_bus.rready = 1'b1; m1_bus.addr = 32'h0000_0900;
    n = 0; nAt = 0; rdAt = '0; terrAt = 1'b0; m0At = 1'b0; terrEarly = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (busy) n++;
      if (m1_bus.rvalid) begin
        nAt = n; rdAt = m1_bus.rdata; terrAt = terr; m0At = m0_bus.rvalid;
        break;
      end
      if (terr) terrEarly = 1'b1;
    end
    checkOutput("tmo busy cycles", 32'(nAt), 32'd8);
    checkOutput("tmo m1_rdata", rdAt, 32'hDEAD_BEEF);
    checkOutput("tmo non-owner rvalid", 32'(m0At), 32'd0);
    checkOutput("tmo err before pulse", 32'(terrEarly), 32'd0);
    checkOutput("tmo err at pulse", 32'(terrAt), 32'd0);
    @(negedge clk);
    m1_bus.rready = 1'b0;
    #1;
    checkOutput("tmo err set", 32'(terr), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("tmo err sticky", 32'(terr), 32'd1);
    checkOutput("tmo idle busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
